// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative multiply/divide beside the ALU.
// Shift-add multiply, restoring divide, one bit per cycle.
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTING,
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic            isDiv;
  logic            divZero;
  logic            negQ;
  logic            negR;
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] op1Raw;

  logic             sgnA;
  logic             sgnB;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;

  assign sgnA = ~MCycleOp[0] & Operand1[WIDTH-1];
  assign sgnB = ~MCycleOp[0] & Operand2[WIDTH-1];
  assign magA = sgnA ? (~Operand1 + 1'b1) : Operand1;
  assign magB = sgnB ? (~Operand2 + 1'b1) : Operand2;

  // multiply step: hiReg is the running upper half, loReg the multiplier
  logic [WIDTH:0]   mulSum;
  logic [WIDTH-1:0] mulHi;
  logic [WIDTH-1:0] mulLo;

  assign mulSum = {1'b0, hiReg}
                + {1'b0, (loReg[0] ? opB : {WIDTH{1'b0}})};
  assign mulHi  = mulSum[WIDTH:1];
  assign mulLo  = {mulSum[0], loReg[WIDTH-1:1]};

  // divide step: hiReg is the partial remainder, loReg shifts in quotient
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] divHi;
  logic [WIDTH-1:0] divLo;

  assign shifted = {hiReg, loReg[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, opB});
  assign divHi   = ge ? (shifted[WIDTH-1:0] - opB)
                      : shifted[WIDTH-1:0];
  assign divLo   = {loReg[WIDTH-2:0], ge};

  logic [WIDTH-1:0] nextHi;
  logic [WIDTH-1:0] nextLo;

  assign nextHi = isDiv ? divHi : mulHi;
  assign nextLo = isDiv ? divLo : mulLo;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quotFix;
  logic [WIDTH-1:0]   remFix;

  assign prod    = {nextHi, nextLo};
  assign prodFix = negQ ? (~prod + 1'b1) : prod;
  assign quotFix = negQ ? (~nextLo + 1'b1) : nextLo;
  assign remFix  = negR ? (~nextHi + 1'b1) : nextHi;

  assign Busy = (state == COMPUTING)
              | ((state == IDLE) & Start);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state   <= IDLE;
      count   <= '0;
      isDiv   <= 1'b0;
      divZero <= 1'b0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      hiReg   <= '0;
      loReg   <= '0;
      opB     <= '0;
      op1Raw  <= '0;
      Result1 <= '0;
      Result2 <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            state   <= COMPUTING;
            count   <= '0;
            isDiv   <= MCycleOp[1];
            divZero <= MCycleOp[1] & (Operand2 == '0);
            negQ    <= sgnA ^ sgnB;
            negR    <= sgnA;
            op1Raw  <= Operand1;
            hiReg   <= '0;
            loReg   <= MCycleOp[1] ? magA : magB;
            opB     <= MCycleOp[1] ? magB : magA;
          end
        end
        COMPUTING: begin
          hiReg <= nextHi;
          loReg <= nextLo;
          count <= count + 1'b1;
          if (count == LAST) begin
            state <= DONE;
            count <= '0;
            unique case (1'b1)
              !isDiv: begin
                Result1 <= prodFix[WIDTH-1:0];
                Result2 <= prodFix[2*WIDTH-1:WIDTH];
              end
              divZero: begin
                Result1 <= '1;
                Result2 <= op1Raw;
              end
              default: begin
                Result1 <= quotFix;
                Result2 <= remFix;
              end
            endcase
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// tb_mcycle_unit: scoreboard bench for mcycle_unit.
// Driver queues model results; negedge monitor checks them.
module tb_mcycle_unit;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RESETn;
  logic         Start;
  logic [1:0]   MCycleOp;
  logic [W-1:0] Operand1;
  logic [W-1:0] Operand2;
  logic [W-1:0] Result1;
  logic [W-1:0] Result2;
  logic         Busy;

  always #5 CLK = ~CLK;

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .Start    (Start),
    .MCycleOp (MCycleOp),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy)
  );

  typedef struct {
    logic [W-1:0] r1;
    logic [W-1:0] r2;
  } exp_t;

  exp_t qExp[$];
  int   nChecks = 0;
  int   nFail   = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] want);
    nChecks++;
    if (act !== want) begin
      nFail++;
      $display("FAIL %s: got %h, required %h", name, act, want);
    end
  endtask

  // architectural result from plain 64-bit arithmetic
  function automatic exp_t model(logic [1:0] op, logic [W-1:0] a,
                                 logic [W-1:0] b);
    exp_t e;
    longint sa;
    longint sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0] p;
    sa = {{32{a[W-1]}}, a};
    sb = {{32{b[W-1]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (!op[1]) begin
      if (op[0]) p = ua * ub;
      else       p = sa * sb;
      e.r1 = p[31:0];
      e.r2 = p[63:32];
    end else if (b == '0) begin
      e.r1 = '1;
      e.r2 = a;
    end else if (op[0]) begin
      p = ua / ub;
      e.r1 = p[31:0];
      p = ua % ub;
      e.r2 = p[31:0];
    end else begin
      p = sa / sb;
      e.r1 = p[31:0];
      p = sa % sb;
      e.r2 = p[31:0];
    end
    return e;
  endfunction

  logic         prevBusy = 1'b0;
  int           busyCnt  = 0;
  logic [W-1:0] held1    = '0;
  logic [W-1:0] held2    = '0;
  exp_t         got;

  always @(negedge CLK) begin
    if (!RESETn) begin
      check("reset_results", {Result2, Result1}, 64'd0);
      prevBusy = 1'b0;
      busyCnt  = 0;
      held1    = '0;
      held2    = '0;
    end else begin
      if (prevBusy && !Busy) begin
        if (qExp.size() == 0) begin
          nChecks++;
          nFail++;
          $display("FAIL spurious_result: got %h_%h, required none",
                   Result2, Result1);
        end else begin
          got = qExp.pop_front();
          check("result1", Result1, got.r1);
          check("result2", Result2, got.r2);
          check("busy_cycles", busyCnt, W + 1);
          held1 = got.r1;
          held2 = got.r2;
        end
        busyCnt = 0;
      end else begin
        check("results_held", {Result2, Result1}, {held2, held1});
      end
      if (Busy) busyCnt++;
      prevBusy = Busy;
    end
  end

  task automatic issue(logic [1:0] op, logic [W-1:0] a,
                       logic [W-1:0] b, bit push);
    Start    = 1'b1;
    MCycleOp = op;
    Operand1 = a;
    Operand2 = b;
    if (push) qExp.push_back(model(op, a, b));
    #1;
    check("accept_busy", Busy, 1);
  endtask

  task automatic waitDone(bit scramble);
    for (int i = 0; i < W + 8; i++) begin
      @(posedge CLK);
      #1;
      if (scramble) begin
        Operand1 = $urandom;
        Operand2 = $urandom;
        MCycleOp = 2'($urandom);
      end
      if (!Busy) return;
    end
    nChecks++;
    nFail++;
    $display("FAIL done_timeout: Busy %b after %0d cycles, required 0",
             Busy, W + 8);
  endtask

  task automatic runOp(logic [1:0] op, logic [W-1:0] a,
                       logic [W-1:0] b, bit scramble);
    @(posedge CLK);
    #1;
    issue(op, a, b, 1'b1);
    waitDone(scramble);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      Start = 1'b0;
      #1;
      check("idle_busy", Busy, 0);
    end
  endtask

  function automatic logic [W-1:0] pick();
    unique case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    RESETn   = 1'b0;
    Start    = 1'b0;
    MCycleOp = 2'b00;
    Operand1 = '0;
    Operand2 = '0;
    #2;
    check("reset_busy_idle", Busy, 0);
    Start = 1'b1;
    #1;
    check("reset_busy_follows_start", Busy, 1);
    Start = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESETn = 1'b1;
    idle(1);

    runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    idle(1);
    runOp(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
    idle(1);
    runOp(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(1);
    runOp(2'b11, 32'd100, 32'd7, 1'b0);
    idle(1);
    runOp(2'b11, 32'h0000_1234, 32'd0, 1'b0);
    idle(1);
    runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(1);
    runOp(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
    idle(1);
    runOp(2'b10, 32'hFFFF_FF9C, 32'd0, 1'b0);
    idle(1);

    @(posedge CLK);
    #1;
    issue(2'b01, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    repeat (11) @(posedge CLK);
    #3;
    RESETn = 1'b0;
    Start  = 1'b0;
    #1;
    check("abort_results", {Result2, Result1}, 64'd0);
    check("abort_busy", Busy, 0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESETn = 1'b1;
    runOp(2'b01, 32'd6, 32'd7, 1'b0);
    idle(1);

    runOp(2'b11, 32'd1000, 32'd33, 1'b1);
    idle(1);
    runOp(2'b00, 32'hFFFF_FFFB, 32'd9, 1'b1);
    runOp(2'b01, 32'd3, 32'd4, 1'b0);
    idle(1);

    for (int k = 0; k < 40; k++) begin
      runOp(2'($urandom), pick(), pick(), 1'($urandom));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
    end

    idle(3);
    check("queue_drained", qExp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
